// File: rtl/aes_keyslot_ctrl.sv
// aes_keyslot_ctrl: register-mapped AES sequencer with lockable key slots.
// Decodes word-indexed register accesses, holds PT/CT/key state and drives a
// start/wait/done handshake toward an external AES core with a timeout guard.
module aes_keyslot_ctrl #(
   parameter int unsigned NUM_KEYS       = 4,
   parameter int unsigned KEY_WORDS      = 6,
   parameter int unsigned TIMEOUT        = 1024,
   parameter int unsigned AXI_ADDR_WIDTH = 64
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          en_i,
   input  logic                          we_i,
   input  logic [AXI_ADDR_WIDTH-1:0]     address_i,
   input  logic [63:0]                   wdata_i,
   output logic [63:0]                   rdata_o,
   input  logic                          debug_mode_i,
   output logic                          core_start_o,
   output logic [127:0]                  core_pt_o,
   output logic [32*KEY_WORDS-1:0]       core_key_o,
   input  logic [127:0]                  core_ct_i,
   input  logic                          core_valid_i
);

   localparam int unsigned CW = $clog2(TIMEOUT);
   localparam int unsigned KW = 32 * KEY_WORDS;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [2:0]        r_key_sel;
   logic [NUM_KEYS-1:0] r_lock;
   logic [31:0]       r_pt [4];
   logic [31:0]       r_ct [4];
   logic [CW-1:0]     r_cnt;
   logic              r_done;
   logic              r_timeout;
   logic              r_error;
   logic              r_to_hit;

   logic [5:0]        w_idx;
   logic              w_wr;
   logic              w_busy;
   logic              w_ctrl_wr;
   logic              w_start_req;
   logic              w_start_ok;
   logic              w_start_rej;
   logic              w_zeroize;
   logic              w_cnt_term;
   logic [31:0]       w_rd32;
   logic [31:0]       w_status;
   logic              w_unused;

   logic [KW-1:0]     w_slot_key [NUM_KEYS];
   logic [KW-1:0]     w_chain    [NUM_KEYS+1];

   assign w_idx       = address_i[8:3];
   assign w_wr        = en_i & we_i;
   assign w_busy      = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
   assign w_ctrl_wr   = w_wr && (w_idx == 6'd0);
   assign w_start_req = w_ctrl_wr && wdata_i[0];
   assign w_start_ok  = w_start_req && (r_state == ST_IDLE) && !debug_mode_i
                        && (32'(r_key_sel) < NUM_KEYS);
   assign w_start_rej = w_start_req && (r_state == ST_IDLE) && !w_start_ok;
   assign w_zeroize   = w_ctrl_wr && wdata_i[2];
   assign w_cnt_term  = (r_cnt == CW'(TIMEOUT - 1));
   assign w_status    = {28'b0, r_error, r_timeout, r_done, w_busy};

   assign w_unused    = &{1'b0, address_i[AXI_ADDR_WIDTH-1:9], address_i[2:0], wdata_i[63:32]};

   // FSM state register
   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // FSM next-state and start pulse
   always_comb begin
      w_state_nxt  = r_state;
      core_start_o = 1'b0;
      case (r_state)
         ST_IDLE:  if (w_start_ok) w_state_nxt = ST_ISSUE;
         ST_ISSUE: begin
            core_start_o = 1'b1;
            w_state_nxt  = ST_WAIT;
         end
         ST_WAIT:  if (core_valid_i || w_cnt_term) w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Control/status registers, PT/CT storage and timeout counter.
   // Flag clears are written before the sets so a set in the same cycle wins;
   // timeout is staged in r_to_hit so it becomes visible together with done.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_key_sel <= '0;
         r_lock    <= '0;
         r_cnt     <= '0;
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
         r_error   <= 1'b0;
         r_to_hit  <= 1'b0;
         for (int unsigned i = 0; i < 4; i++) begin
            r_pt[i] <= '0;
            r_ct[i] <= '0;
         end
      end else begin
         if (w_ctrl_wr && wdata_i[1]) begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_error   <= 1'b0;
         end
         if (w_start_rej) r_error <= 1'b1;

         case (r_state)
            ST_ISSUE: begin
               r_cnt    <= '0;
               r_to_hit <= 1'b0;
            end
            ST_WAIT: begin
               if (core_valid_i) begin
                  r_ct[0] <= core_ct_i[31:0];
                  r_ct[1] <= core_ct_i[63:32];
                  r_ct[2] <= core_ct_i[95:64];
                  r_ct[3] <= core_ct_i[127:96];
               end else if (w_cnt_term) begin
                  r_to_hit <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               r_done <= 1'b1;
               if (r_to_hit) r_timeout <= 1'b1;
            end
            default: ;
         endcase

         if (w_wr) begin
            if (w_idx == 6'd2 && !w_busy) r_key_sel <= wdata_i[2:0];
            if (w_idx == 6'd3)            r_lock    <= r_lock | wdata_i[NUM_KEYS-1:0];
            if (w_idx[5:2] == 4'd1 && !w_busy) r_pt[w_idx[1:0]] <= wdata_i[31:0];
         end
      end
   end

   for (genvar gk = 0; gk < NUM_KEYS; gk++) begin : g_slot
      logic w_sel_hit;

      for (genvar gw = 0; gw < KEY_WORDS; gw++) begin : g_word
         localparam logic [5:0] IDX = 6'(16 + gk * KEY_WORDS + gw);
         logic [31:0] r_word;

         // Key word storage: write or zeroize only when idle and slot unlocked
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               r_word <= '0;
            end else if (!w_busy && !r_lock[gk]) begin
               if (w_zeroize)                   r_word <= '0;
               else if (w_wr && (w_idx == IDX)) r_word <= wdata_i[31:0];
            end
         end

         assign w_slot_key[gk][32*gw +: 32] = r_word;
      end

      // Out-of-range KEY_SEL matches no slot, so the chain yields zero.
      assign w_sel_hit      = (r_key_sel == 3'(gk));
      assign w_chain[gk+1]  = w_chain[gk] | (w_sel_hit ? w_slot_key[gk] : '0);
   end

   assign w_chain[0] = '0;
   assign core_key_o = debug_mode_i ? '0 : w_chain[NUM_KEYS];
   assign core_pt_o  = {r_pt[3], r_pt[2], r_pt[1], r_pt[0]};

   // Combinational read mux; key words are write-only and read as zero
   always_comb begin
      w_rd32 = '0;
      if (en_i) begin
         case (w_idx)
            6'd1:                   w_rd32 = w_status;
            6'd2:                   w_rd32 = {29'b0, r_key_sel};
            6'd3:                   w_rd32[NUM_KEYS-1:0] = r_lock;
            6'd4, 6'd5, 6'd6, 6'd7:     w_rd32 = r_pt[w_idx[1:0]];
            6'd8, 6'd9, 6'd10, 6'd11:   w_rd32 = r_ct[w_idx[1:0]];
            default:                w_rd32 = '0;
         endcase
      end
   end

   assign rdata_o = {32'b0, w_rd32};

endmodule
